ring_osc_meter: RTL and testbench
=================================

Name: ring_osc_meter

Overview:
Downstream measurement stage for the instrumented adder.
- The adder's ring oscillator output (chain_out) is asynchronous to the system clock. This block synchronises it and counts its rising edges over a programmable gate window.
- It reports the edge count through a start/busy/done handshake, which firmware reads over the logic analyser bus.
- The block also drives the ring enable, so the oscillator runs only inside a measurement.

Parameters:
- CNT_W, 32, width of the edge counter and count output.
- GATE_W, 16, width of the gate_cycles input.
- SETTLE, 4, number of clock cycles the ring runs before counting starts (range 1..15).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_n  input  1  asynchronous active-low reset.
- active  input  1  design-select. 0 forces abort/idle.
- ring_in  input  1  ring oscillator output (chain_out), asynchronous.
- gate_cycles  input  GATE_W  counting window length in clocks; sampled on start.
- start  input  1  one-cycle request pulse.
- ring_enable  output  1  enables the adder ring oscillator.
- busy  output  1  measurement in progress.
- done  output  1  one-cycle pulse when count becomes valid.
- count  output  CNT_W  edges counted in the last completed measurement.
- overflow  output  1  counter saturated during the last measurement.

Behaviour:
- Reset (async assert, sync release): state IDLE. ring_enable, busy, done, count, overflow all 0. Synchroniser flops 0.
- Synchroniser: 2 flops on ring_in, plus a third flop for edge detection. rise = s2 & ~s3.
  - Valid only for ring frequency < wb_clk_i/2. Faster rings alias; this is a documented limitation, not an error.
- FSM states: IDLE, SETTLE, COUNT, FLUSH, DONE.
- IDLE:
  - start=1 with active=1 at edge t: latch gate_cycles into gate_reg, clear the edge counter and overflow.
  - ring_enable=1 and busy=1 from t+1; enter SETTLE.
  - start with active=0 is ignored.
- SETTLE: hold SETTLE cycles; rises are not counted. Then enter COUNT.
  - If gate_reg==0, go straight to FLUSH: zero-length window, count=0.
- COUNT: lasts exactly gate_reg cycles. Each cycle with rise=1 increments the counter.
  - At all-ones the counter holds its value and sets overflow (sticky).
- FLUSH: ring_enable=0 on entry. Lasts 2 cycles; rises are not counted. Then enter DONE.
- DONE: count register loads the edge counter; overflow is updated; done=1 for this single cycle. busy=0 from the next cycle; return to IDLE.
- Cycle budget: start accepted at edge t gives done high in cycle t + SETTLE + gate_reg + 3.
- count and overflow hold their values until the next DONE. They are not cleared by a new start; the internal counter is cleared instead.
- start while busy=1: ignored, with no effect on the window.
- active falls in any non-IDLE state: next edge goes to IDLE.
  - ring_enable=0, busy=0, done not pulsed.
  - count and overflow keep their previous values.
- start and active falling in the same cycle while IDLE: no start.
- gate_cycles changes during a measurement: no effect, because the value is latched.
- Reset mid-operation: immediate return to the reset values above, including count.

Test Plan:
1. Reset with ring_in toggling -> all outputs 0. No done while wb_rst_n=0 or for 20 cycles after release with no start.
2. ring_in = period 10 clocks (50% duty), gate_cycles=100, start -> ring_enable high from the next cycle; done exactly SETTLE+103 = 107 cycles after the start edge; count=10 (±1 from phase); overflow=0; busy low afterwards.
3. gate_cycles=0, start -> done 4+3 = 7 cycles after start; count=0; overflow=0.
4. CNT_W overridden to 4, ring period 4 clocks, gate_cycles=100 -> count=15, overflow=1. A following measurement with gate_cycles=8 -> count=2, overflow=0.
5. Start, then drop active 20 cycles in -> busy and ring_enable low next cycle; no done; count still equals the previous result. A second start while busy is ignored: done timing stays as in scenario 2.
6. Assert wb_rst_n=0 asynchronously mid-COUNT -> outputs 0 immediately, before the next clock edge. A fresh start after release completes normally with the scenario-2 values.

Source files
------------

// File: rtl/ring_osc_meter.sv
// Ring oscillator edge meter: synchronises the adder's ring output and counts its
// rising edges over a programmable gate window, with a start/busy/done handshake.
module ring_osc_meter #(
    parameter int CNT_W  = 32,
    parameter int GATE_W = 16,
    parameter int SETTLE = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              active,
    input  logic              ring_in,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    output logic              ring_enable,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    // Phase timer must hold both the settle length (up to 15) and any gate length.
    localparam int TW = (GATE_W > 4) ? GATE_W : 4;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              w_rise;
    logic [GATE_W-1:0] r_gate;
    logic [TW-1:0]     r_cyc;
    logic [TW-1:0]     w_gate_last;
    logic              w_phase_end;
    logic [CNT_W-1:0]  r_edges;
    logic              r_ovf_run;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    assign w_rise      = r_s2 & ~r_s3;
    assign w_gate_last = TW'(r_gate) - TW'(1);
    assign w_phase_end = (w_state_nxt != r_state);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ring_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cyc == SETTLE_LAST)
                          w_state_nxt = (r_gate == '0) ? S_FLUSH : S_COUNT;
            S_COUNT:  if (r_cyc == w_gate_last) w_state_nxt = S_FLUSH;
            S_FLUSH:  if (r_cyc == TW'(1)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // Losing the design select aborts from anywhere, and blocks a start in IDLE.
        if (!active) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_gate     <= '0;
            r_edges    <= '0;
            r_ovf_run  <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || w_phase_end) r_cyc <= '0;
            else                                  r_cyc <= r_cyc + TW'(1);

            if (r_state == S_IDLE && w_state_nxt == S_SETTLE) begin
                r_gate    <= gate_cycles;
                r_edges   <= '0;
                r_ovf_run <= 1'b0;
            end else if (r_state == S_COUNT && w_rise) begin
                // Saturate rather than wrap so a too-fast ring is flagged, not hidden.
                if (r_edges == {CNT_W{1'b1}}) r_ovf_run <= 1'b1;
                else                          r_edges   <= r_edges + CNT_W'(1);
            end

            if (r_state == S_FLUSH && w_state_nxt == S_DONE) begin
                r_count    <= r_edges;
                r_overflow <= r_ovf_run;
            end
        end
    end

    assign ring_enable = (r_state == S_SETTLE) || (r_state == S_COUNT);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: default instance plus a CNT_W=4 instance for saturation.
module tb_ring_osc_meter;

    logic        clk;
    logic        rst_n;
    logic        active;
    logic        ring_in;
    logic [15:0] gate_cycles;
    logic        start;
    logic        ring_enable;
    logic        busy;
    logic        done;
    logic [31:0] count;
    logic        overflow;
    logic        ring_enable4;
    logic        busy4;
    logic        done4;
    logic [3:0]  count4;
    logic        overflow4;

    int n_cmp = 0;
    int n_bad = 0;
    int ring_period = 0;
    int ring_ph = 0;

    ring_osc_meter dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .active(active), .ring_in(ring_in),
        .gate_cycles(gate_cycles), .start(start), .ring_enable(ring_enable),
        .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    ring_osc_meter #(.CNT_W(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .active(active), .ring_in(ring_in),
        .gate_cycles(gate_cycles), .start(start), .ring_enable(ring_enable4),
        .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ring model: square wave of ring_period clocks, skewed off the clock edge.
    initial begin
        ring_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ring_period == 0) begin
                ring_in = 1'b0;
                ring_ph = 0;
            end else begin
                ring_ph = (ring_ph + 1) % ring_period;
                ring_in = (ring_ph < ring_period / 2);
            end
        end
    end

    task automatic run_measure(input int gate, output int lat, output logic en1,
                               output logic [31:0] cnt, output logic ovf,
                               output logic [3:0] cnt4, output logic ovf4,
                               output logic busy_after);
        @(negedge clk);
        gate_cycles = 16'(gate);
        active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en1 = ring_enable & busy;
        lat = -1;
        cnt = '1;
        ovf = 1'bx;
        cnt4 = '1;
        ovf4 = 1'bx;
        busy_after = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                lat = c;
                cnt = count;
                ovf = overflow;
                cnt4 = count4;
                ovf4 = overflow4;
                break;
            end
            @(negedge clk);
        end
        if (lat >= 0) begin
            @(negedge clk);
            busy_after = busy;
        end
    endtask

    task automatic test_reset();
        logic seen_done;
        ring_period = 6;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ring_enable, busy, done, overflow, count} !== 36'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h required 0", {ring_enable, busy, done, overflow, count});
            end
        end
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_no_done: got activity=%b required 0", seen_done);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic en1, ovf, ovf4, busy_after;
        logic [31:0] cnt;
        logic [3:0] cnt4;
        ring_period = 10;
        run_measure(100, lat, en1, cnt, ovf, cnt4, ovf4, busy_after);
        n_cmp++;
        if (en1 !== 1'b1) begin n_bad++; $display("FAIL basic_enable: got %b required 1", en1); end
        n_cmp++;
        if (lat !== 107) begin n_bad++; $display("FAIL basic_latency: got %0d required 107", lat); end
        n_cmp++;
        if (cnt < 32'd9 || cnt > 32'd11) begin n_bad++; $display("FAIL basic_count: got %0d required 10+-1", cnt); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %b required 0", ovf); end
        n_cmp++;
        if (busy_after !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b required 0", busy_after); end
    endtask

    task automatic test_zero_gate();
        int lat;
        logic en1, ovf, ovf4, busy_after;
        logic [31:0] cnt;
        logic [3:0] cnt4;
        ring_period = 10;
        run_measure(0, lat, en1, cnt, ovf, cnt4, ovf4, busy_after);
        n_cmp++;
        if (lat !== 7) begin n_bad++; $display("FAIL zero_latency: got %0d required 7", lat); end
        n_cmp++;
        if (cnt !== 32'd0) begin n_bad++; $display("FAIL zero_count: got %0d required 0", cnt); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL zero_overflow: got %b required 0", ovf); end
    endtask

    task automatic test_overflow();
        int lat;
        logic en1, ovf, ovf4, busy_after;
        logic [31:0] cnt;
        logic [3:0] cnt4;
        ring_period = 4;
        run_measure(100, lat, en1, cnt, ovf, cnt4, ovf4, busy_after);
        n_cmp++;
        if (cnt !== 32'd25) begin n_bad++; $display("FAIL ovf_wide_count: got %0d required 25", cnt); end
        n_cmp++;
        if (cnt4 !== 4'd15) begin n_bad++; $display("FAIL ovf_narrow_count: got %0d required 15", cnt4); end
        n_cmp++;
        if (ovf4 !== 1'b1) begin n_bad++; $display("FAIL ovf_narrow_flag: got %b required 1", ovf4); end
        run_measure(8, lat, en1, cnt, ovf, cnt4, ovf4, busy_after);
        n_cmp++;
        if (lat !== 15) begin n_bad++; $display("FAIL ovf_short_latency: got %0d required 15", lat); end
        n_cmp++;
        if (cnt4 !== 4'd2) begin n_bad++; $display("FAIL ovf_short_count: got %0d required 2", cnt4); end
        n_cmp++;
        if (ovf4 !== 1'b0) begin n_bad++; $display("FAIL ovf_short_flag: got %b required 0", ovf4); end
        n_cmp++;
        if (cnt !== 32'd2) begin n_bad++; $display("FAIL ovf_short_wide_count: got %0d required 2", cnt); end
    endtask

    task automatic test_abort();
        logic seen_done;
        ring_period = 10;
        @(negedge clk);
        gate_cycles = 16'd100;
        active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 19; i++) @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, ring_enable} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy/en=%b required 00", {busy, ring_enable});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b required 0", seen_done); end
        n_cmp++;
        if (count !== 32'd2 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_keeps_result: got count=%0d ovf=%b required 2/0", count, overflow);
        end
        // Start while the design is deselected must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL inactive_start: got busy=%b required 0", busy); end
        active = 1'b1;
    endtask

    task automatic test_start_while_busy();
        int lat;
        ring_period = 10;
        @(negedge clk);
        gate_cycles = 16'd100;
        active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            if (c == 30) begin
                start = 1'b1;
                gate_cycles = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (lat !== 107) begin n_bad++; $display("FAIL busy_start_latency: got %0d required 107", lat); end
        n_cmp++;
        if (count < 32'd9 || count > 32'd11) begin
            n_bad++;
            $display("FAIL busy_start_count: got %0d required 10+-1", count);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle: got busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic en1, ovf, ovf4, busy_after;
        logic [31:0] cnt;
        logic [3:0] cnt4;
        ring_period = 10;
        @(negedge clk);
        gate_cycles = 16'd100;
        active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) @(negedge clk);
        n_cmp++;
        if ({busy, ring_enable} !== 2'b11) begin
            n_bad++;
            $display("FAIL midreset_pre: got busy/en=%b required 11", {busy, ring_enable});
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ring_enable, busy, done, overflow, count} !== 36'd0) begin
            n_bad++;
            $display("FAIL midreset_async: got %h required 0", {ring_enable, busy, done, overflow, count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_measure(100, lat, en1, cnt, ovf, cnt4, ovf4, busy_after);
        n_cmp++;
        if (lat !== 107) begin n_bad++; $display("FAIL midreset_latency: got %0d required 107", lat); end
        n_cmp++;
        if (cnt < 32'd9 || cnt > 32'd11) begin n_bad++; $display("FAIL midreset_count: got %0d required 10+-1", cnt); end
        n_cmp++;
        if (ovf !== 1'b0 || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_tail: got ovf=%b busy=%b required 0/0", ovf, busy_after);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        active = 1'b0;
        start = 1'b0;
        gate_cycles = '0;
        test_reset();
        active = 1'b1;
        test_basic();
        test_zero_gate();
        test_overflow();
        test_abort();
        test_start_while_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
